fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the control unit. It owns the program counter, reads 16-bit instruction words from the synchronous instruction ROM, latches each one into an instruction register and presents the decoded fields to the control unit under a valid/stall handshake. It also resolves the two control-flow opcodes the control unit does not handle: JMP and HALT.

## Interface
- ADDR_W, 8, ROM address and PC width
- INSTR_W, 16, instruction word width
- RESET_PC, 8'h00, PC value after reset
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins fetching from IDLE
- stall  in  1  control unit not ready; holds the current instruction
- rom_address  out  ADDR_W  equals PC
- rom_read_enable  out  1  ROM read strobe
- rom_data  in  INSTR_W  ROM word, valid the cycle after the strobe
- instr_valid  out  1  opcode/fields hold a live instruction
- opcode  out  4  IR[15:12]
- dst  out  4  IR[11:8]
- src  out  4  IR[7:4]
- imm  out  8  IR[7:0]
- pc  out  ADDR_W  address of the instruction in IR
- busy  out  1  state is neither IDLE nor HALTED
- halted  out  1  HALT has been accepted

## Operation
- States: IDLE, REQ, WAIT, ISSUE, HALTED.
- IDLE: outputs quiescent. start=1 -> REQ. Otherwise stay.
- REQ: rom_read_enable=1, rom_address=PC -> WAIT.
- WAIT: rom_read_enable=0. IR <= rom_data at the end of the cycle -> ISSUE.
- ISSUE: instr_valid=1. Fields are driven from IR and held stable while stall=1.
- Acceptance occurs on a cycle with instr_valid=1 and stall=0.
- On acceptance, selected by opcode:
  - 4'b1111 HALT -> HALTED. PC unchanged.
  - 4'b1100 JMP -> PC <= imm, then REQ.
  - Any other opcode, including 0000 NOP and 0001–1011 ALU/MOV -> PC <= PC+1, then REQ.
- JMP and HALT are still presented to the control unit, which decodes them as default (no RAM/ALU action).
- PC increment is modulo 2^ADDR_W: 8'hFF+1 -> 8'h00, with no flag.
- HALTED: instr_valid=0, halted=1. Left only via rst. start is ignored.
- start is ignored in every state except IDLE.
- stall is ignored outside ISSUE.

## Timing
- Reset values: PC=RESET_PC, IR=0, state=IDLE, rom_read_enable=0, instr_valid=0, opcode/dst/src/imm=0, busy=0, halted=0.
- Reset mid-operation: rst takes effect at the next edge from any state. An in-flight ROM word is discarded and IR is cleared.
- Latency: start sampled at edge N -> REQ in cycle N+1 -> WAIT N+2 -> instr_valid=1 in cycle N+3.
- Throughput: 3 cycles per instruction when stall=0. Each stall cycle adds one cycle.
- After acceptance at edge M, instr_valid=0 in cycles M+1 (REQ) and M+2 (WAIT), and returns to 1 in cycle M+3.
- rom_read_enable is high for exactly one cycle per fetch. rom_address is stable during REQ and WAIT.
- A jump target takes effect on the fetch immediately following acceptance; there is no delay slot.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_NOP=0000, OP_MOV=0001, OP_ADD=0010 … OP_EQ=1011, OP_JMP=1100, OP_HALT=1111
  - the fetch state enum
  - instruction field bit positions
- The control unit imports the same opcode constants.
- One sub-module, program_counter, provides:
  - an ADDR_W register with synchronous reset to RESET_PC
  - inputs load, load_val, inc, with load taking priority over inc
- The FSM, IR and field extraction live in fetch_unit.

## Test plan
- Reset, then start with ROM[0..2]=2123, 3456, 0000 -> three issues with opcode 2, 3, 0 and pc 0, 1, 2. Each instr_valid appears 3 cycles after the previous acceptance.
- stall=1 for 4 cycles during ISSUE of 2123 -> opcode/dst/src/pc held constant and rom_read_enable stays 0. Next fetch begins the cycle after stall falls.
- ROM[5]=C0A0 (JMP 0xA0), ROM[A0]=F000 -> next rom_address=A0 after acceptance. After HALT is accepted: halted=1, busy=0, instr_valid=0, and further start pulses are ignored.
- RESET_PC=FF with ROM[FF]=0000 -> the fetch after acceptance uses rom_address=00 (wrap).
- rst asserted during WAIT -> next cycle state is IDLE with PC=RESET_PC, IR=0 and all outputs at their reset values. A later start refetches from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, fetch FSM states and
// instruction field positions used by fetch and control units.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_LT   = 4'b1010;
  localparam logic [3:0] OP_EQ   = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ISSUE,
    ST_HALTED
  } fetch_state_e;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned DST_LSB = 8;
  localparam int unsigned SRC_LSB = 4;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned IMM_W   = 8;

endpackage

// File: rtl/fetch_unit_if.sv
// ROM bus plus control-unit issue handshake; master side is the fetch unit.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic [ADDR_W-1:0]  rom_address;
  logic               rom_read_enable;
  logic [INSTR_W-1:0] rom_data;
  logic               instr_valid;
  logic               stall;
  logic [3:0]         opcode;
  logic [3:0]         dst;
  logic [3:0]         src;
  logic [7:0]         imm;
  logic [ADDR_W-1:0]  pc;

  modport master (
    output rom_address, rom_read_enable, instr_valid, opcode, dst, src, imm, pc,
    input  rom_data, stall
  );

  modport slave (
    input  rom_address, rom_read_enable, instr_valid, opcode, dst, src, imm, pc,
    output rom_data, stall
  );
endinterface

// File: rtl/fetch_unit_program_counter.sv
// Program counter register: load has priority over increment, wraps modulo 2^ADDR_W.
module program_counter #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);
  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC/ROM sequencing, instruction register, field
// decode and valid/stall issue to the control unit; resolves JMP and HALT.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          halted,
  fetch_unit_if.master  bus
);
  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               pc_load, pc_inc;
  logic               rom_re, valid;
  logic [ADDR_W-1:0]  pc_val;
  logic [3:0]         opc;
  logic [IMM_W-1:0]   imm_f;

  assign opc   = ir_q[OPC_LSB +: REG_W];
  assign imm_f = ir_q[IMM_LSB +: IMM_W];

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (ADDR_W'(imm_f)),
    .inc      (pc_inc),
    .pc       (pc_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    rom_re  = 1'b0;
    valid   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        rom_re  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        ir_d    = bus.rom_data;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        valid = 1'b1;
        // Control flow resolves here on acceptance; PC is untouched while stalled.
        if (!bus.stall) begin
          if (opc == OP_HALT) begin
            state_d = ST_HALTED;
          end else begin
            pc_load = (opc == OP_JMP);
            pc_inc  = (opc != OP_JMP);
            state_d = ST_REQ;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.rom_address     = pc_val;
  assign bus.rom_read_enable = rom_re;
  assign bus.instr_valid     = valid;
  assign bus.opcode          = opc;
  assign bus.dst             = ir_q[DST_LSB +: REG_W];
  assign bus.src             = ir_q[SRC_LSB +: REG_W];
  assign bus.imm             = imm_f;
  assign bus.pc              = pc_val;
  assign busy                = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign halted              = (state_q == ST_HALTED);
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: sequential issue, stall hold, JMP/HALT,
// PC wrap (second instance at RESET_PC=FF) and reset during WAIT.
module tb_fetch_unit;
  typedef struct {
    logic [3:0] opcode;
    logic [3:0] dst;
    logic [3:0] src;
    logic [7:0] imm;
    logic [7:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start0, start1;
  logic busy0, halted0, busy1, halted1;
  logic [15:0] rom0 [256];
  logic [15:0] rom1 [256];
  exp_t exp_q [$];
  exp_t e;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned lat;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus0 ();
  fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus1 ();

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .halted(halted0), .bus(bus0)
  );
  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFF)) u_wrap (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .halted(halted1), .bus(bus1)
  );

  always @(posedge clk) begin
    if (bus0.rom_read_enable) bus0.rom_data <= rom0[bus0.rom_address];
    if (bus1.rom_read_enable) bus1.rom_data <= rom1[bus1.rom_address];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void push(input logic [7:0] pc, input logic [15:0] w);
    exp_t x;
    x.opcode = w[15:12];
    x.dst    = w[11:8];
    x.src    = w[7:4];
    x.imm    = w[7:0];
    x.pc     = pc;
    exp_q.push_back(x);
  endfunction

  // Waits (bounded) for instr_valid on DUT0 and compares against the scoreboard head.
  task automatic expect_issue0();
    while (!bus0.instr_valid && lat < 12) begin
      if (lat == 2) check_eq("wait_re", bus0.rom_read_enable, 1'b0);
      tick();
      lat++;
    end
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_eq("latency", lat, 3);
      check_eq("opcode", bus0.opcode, e.opcode);
      check_eq("dst", bus0.dst, e.dst);
      check_eq("src", bus0.src, e.src);
      check_eq("imm", bus0.imm, e.imm);
      check_eq("pc", bus0.pc, e.pc);
    end
  endtask

  initial begin
    bit first;
    for (int i = 0; i < 256; i++) begin
      rom0[i] = 16'h0000;
      rom1[i] = 16'h0000;
    end
    rom0[8'h00] = 16'h2123;
    rom0[8'h01] = 16'h3456;
    rom0[8'h05] = 16'hC0A0;
    rom0[8'hA0] = 16'hF000;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    bus0.stall = 1'b0; bus1.stall = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b0;

    check_eq("rst_valid", bus0.instr_valid, 1'b0);
    check_eq("rst_re", bus0.rom_read_enable, 1'b0);
    check_eq("rst_busy", busy0, 1'b0);
    check_eq("rst_halted", halted0, 1'b0);
    check_eq("rst_opcode", {bus0.opcode, bus0.dst, bus0.imm}, 16'h0000);
    check_eq("rst_pc", bus0.pc, 8'h00);
    check_eq("rst_pc_wrap", bus1.pc, 8'hFF);

    push(8'h00, 16'h2123); push(8'h01, 16'h3456); push(8'h02, 16'h0000);
    push(8'h03, 16'h0000); push(8'h04, 16'h0000); push(8'h05, 16'hC0A0);
    push(8'hA0, 16'hF000);

    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    lat = 1;
    check_eq("start_re", bus0.rom_read_enable, 1'b1);
    check_eq("start_addr", bus0.rom_address, 8'h00);
    check_eq("start_busy", busy0, 1'b1);
    first = 1'b1;
    while (exp_q.size() > 0) begin
      expect_issue0();
      if (first) begin
        first = 1'b0;
        bus0.stall = 1'b1;
        repeat (4) begin
          tick();
          check_eq("stall_valid", bus0.instr_valid, 1'b1);
          check_eq("stall_re", bus0.rom_read_enable, 1'b0);
          check_eq("stall_fields", {bus0.opcode, bus0.dst, bus0.src}, 12'h212);
          check_eq("stall_pc", bus0.pc, 8'h00);
        end
        bus0.stall = 1'b0;
      end
      tick();
      lat = 1;
      if (e.opcode == 4'hF) begin
        check_eq("halt_halted", halted0, 1'b1);
        check_eq("halt_busy", busy0, 1'b0);
        check_eq("halt_valid", bus0.instr_valid, 1'b0);
        check_eq("halt_pc", bus0.pc, 8'hA0);
      end else if (exp_q.size() > 0) begin
        check_eq("next_re", bus0.rom_read_enable, 1'b1);
        check_eq("next_addr", bus0.rom_address, exp_q[0].pc);
        check_eq("next_valid", bus0.instr_valid, 1'b0);
      end
    end

    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (3) begin
      check_eq("halt_start_re", bus0.rom_read_enable, 1'b0);
      tick();
    end
    check_eq("halt_stays", halted0, 1'b1);
    check_eq("halt_stays_busy", busy0, 1'b0);

    // Wrap instance: RESET_PC=FF, ROM all NOP.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 1;
    while (!bus1.instr_valid && lat < 12) begin
      tick();
      lat++;
    end
    check_eq("wrap_lat", lat, 3);
    check_eq("wrap_pc", bus1.pc, 8'hFF);
    tick();
    check_eq("wrap_re", bus1.rom_read_enable, 1'b1);
    check_eq("wrap_addr", bus1.rom_address, 8'h00);

    // Reset during WAIT on DUT0 after a non-zero IR is loaded.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst2_halted", halted0, 1'b0);
    push(8'h00, 16'h2123);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    lat = 1;
    expect_issue0();
    tick();
    tick();
    check_eq("pre_rst_pc", bus0.pc, 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rw_busy", busy0, 1'b0);
    check_eq("rw_valid", bus0.instr_valid, 1'b0);
    check_eq("rw_re", bus0.rom_read_enable, 1'b0);
    check_eq("rw_ir", {bus0.opcode, bus0.dst, bus0.imm}, 16'h0000);
    check_eq("rw_pc", bus0.pc, 8'h00);
    check_eq("rw_halted", halted0, 1'b0);
    tick();
    check_eq("rw_idle_busy", busy0, 1'b0);
    push(8'h00, 16'h2123);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    lat = 1;
    check_eq("refetch_addr", bus0.rom_address, 8'h00);
    expect_issue0();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
